// File: rtl/tmds_pkg.sv
// TMDS lane receiver shared definitions.
// Control tokens are shared with the transmitter side.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctrl;
    } tok_match_t;

    function automatic tok_match_t match_token(input logic [9:0] w);
        tok_match_t m;
        m.hit  = 1'b1;
        m.ctrl = 2'b00;
        unique case (1'b1)
            (w == TOK_C00): m.ctrl = 2'b00;
            (w == TOK_C01): m.ctrl = 2'b01;
            (w == TOK_C10): m.ctrl = 2'b10;
            (w == TOK_C11): m.ctrl = 2'b11;
            default:        m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmds_decode_10to8.sv
// Combinational TMDS symbol decoder.
// Classifies a 10-bit word as control token or pixel data.
module tmds_decode_10to8
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       is_token
);

    tok_match_t tok;
    logic [7:0] x;

    // token lookup, then undo the DC inversion and the xor/xnor chain
    always_comb begin
        tok      = match_token(word);
        x        = word[9] ? ~word[7:0] : word[7:0];
        data     = '0;
        data[0]  = x[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = word[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        end
        ctrl     = tok.ctrl;
        is_token = tok.hit;
        de       = ~tok.hit;
    end

endmodule

// File: rtl/tmds_lane_receiver.sv
// One TMDS lane: 2-bit DDR capture, token-based word alignment,
// symbol decode. Alignment moves one bit later per slip.
module tmds_lane_receiver
    import tmds_pkg::*;
#(
    parameter int C_lock_count  = 8,
    parameter int C_slip_after  = 16,
    parameter int C_loss_window = 4096
) (
    input  logic       clk_shift,
    input  logic       rst_n,
    input  logic [1:0] in_bits,
    output logic       sym_valid,
    output logic [9:0] sym,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_count
);

    localparam int HW = $clog2(C_lock_count + 1);
    localparam int MW = $clog2(C_slip_after + 1);
    localparam int LW = $clog2(C_loss_window + 1);

    localparam logic [HW-1:0] HIT_LAST  = HW'(C_lock_count - 1);
    localparam logic [MW-1:0] MISS_MAX  = MW'(C_slip_after);
    localparam logic [LW-1:0] LOSS_LAST = LW'(C_loss_window - 1);

    rx_state_e   state, state_d;
    logic [11:0] sr;
    logic [2:0]  phase, phase_d;
    logic        offset, offset_d;
    logic [HW-1:0] hit, hit_d;
    logic [MW-1:0] miss, miss_d;
    logic [LW-1:0] loss, loss_d;
    logic [3:0]  slip_d;
    logic [9:0]  word;
    logic        strobe;
    logic        slip;
    logic [7:0]  dec_data;
    logic [1:0]  dec_ctrl;
    logic        dec_de;
    logic        dec_tok;

    assign word   = offset ? sr[10:1] : sr[9:0];
    assign slip   = (state == ST_SEARCH) && (miss == MISS_MAX);
    assign strobe = (phase == 3'd4) && !slip;
    assign locked = (state == ST_LOCKED);

    tmds_decode_10to8 u_dec (
        .word     (word),
        .data     (dec_data),
        .ctrl     (dec_ctrl),
        .de       (dec_de),
        .is_token (dec_tok)
    );

    // next alignment, phase and lock-tracking state
    always_comb begin
        state_d  = state;
        hit_d    = hit;
        miss_d   = miss;
        loss_d   = loss;
        offset_d = offset;
        slip_d   = slip_count;
        phase_d  = (phase == 3'd4) ? 3'd0 : phase + 3'd1;
        if (slip) begin
            offset_d = ~offset;
            slip_d   = (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
            hit_d    = '0;
            miss_d   = '0;
            if (offset) begin
                phase_d = phase;
            end
        end else if (strobe) begin
            unique case (state)
                ST_SEARCH: begin
                    if (dec_tok) begin
                        miss_d = '0;
                        if (hit == HIT_LAST) begin
                            state_d = ST_LOCKED;
                            hit_d   = '0;
                            loss_d  = '0;
                        end else begin
                            hit_d = hit + HW'(1);
                        end
                    end else begin
                        hit_d = '0;
                        if (miss != MISS_MAX) begin
                            miss_d = miss + MW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (dec_tok) begin
                        loss_d = '0;
                    end else if (loss == LOSS_LAST) begin
                        state_d = ST_SEARCH;
                        loss_d  = '0;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        loss_d = loss + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // capture shift register and alignment/FSM state registers
    always_ff @(posedge clk_shift) begin
        if (!rst_n) begin
            sr         <= '0;
            phase      <= '0;
            offset     <= 1'b0;
            state      <= ST_SEARCH;
            hit        <= '0;
            miss       <= '0;
            loss       <= '0;
            slip_count <= '0;
        end else begin
            sr         <= {in_bits[1], in_bits[0], sr[11:2]};
            phase      <= phase_d;
            offset     <= offset_d;
            state      <= state_d;
            hit        <= hit_d;
            miss       <= miss_d;
            loss       <= loss_d;
            slip_count <= slip_d;
        end
    end

    // register the aligned symbol and its decode on each strobe
    always_ff @(posedge clk_shift) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            sym       <= '0;
            data      <= '0;
            ctrl      <= '0;
            de        <= 1'b0;
        end else begin
            sym_valid <= strobe;
            if (strobe) begin
                sym <= word;
                de  <= dec_de;
                if (dec_tok) begin
                    ctrl <= dec_ctrl;
                end else begin
                    data <= dec_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmds_lane_receiver.sv
// Bench for tmds_lane_receiver: bit-stream reference model
// tracking symbol start positions, lock and slip rules.
module tb_tmds_lane_receiver;

    logic       clk_shift = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_bits = 2'b00;
    logic       sym_valid;
    logic [9:0] sym;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] slip_count;

    tmds_lane_receiver dut (
        .clk_shift  (clk_shift),
        .rst_n      (rst_n),
        .in_bits    (in_bits),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .data       (data),
        .ctrl       (ctrl),
        .de         (de),
        .locked     (locked),
        .slip_count (slip_count)
    );

    always #5 clk_shift = ~clk_shift;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    bit pend[$];
    bit hist[$];

    function automatic int tok_idx(input logic [9:0] w);
        if (w == 10'b1101010100) return 0;
        if (w == 10'b0010101011) return 1;
        if (w == 10'b0101010100) return 2;
        if (w == 10'b1010101011) return 3;
        return -1;
    endfunction

    function automatic logic [9:0] tok_word(input int i);
        case (i)
            0: return 10'b1101010100;
            1: return 10'b0010101011;
            2: return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] w);
        logic [7:0] x, d;
        x = w[7:0];
        if (w[9]) x = ~x;
        d[0] = x[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = x[i] ^ x[i-1];
            if (!w[8]) d[i] = ~d[i];
        end
        return d;
    endfunction

    function automatic logic [9:0] win(input int s);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) begin
            if (s + j >= 0 && s + j < hist.size()) w[j] = hist[s+j];
            else w[j] = 1'b0;
        end
        return w;
    endfunction

    // reference model state
    int m_k, m_nxt, m_kexp, m_hit, m_miss, m_loss, m_slip;
    bit m_lock, m_pend, m_de;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;

    task automatic model_reset();
        m_k = 0; m_nxt = -4; m_kexp = 4;
        m_hit = 0; m_miss = 0; m_loss = 0; m_slip = 0;
        m_lock = 0; m_pend = 0; m_de = 0;
        m_data = '0; m_ctrl = '0;
    endtask

    task automatic model_edge();
        bit exp_v;
        logic [9:0] w;
        int t, step;
        if (m_pend) begin
            m_pend = 0;
            m_slip = (m_slip + 1) % 10;
        end
        exp_v = (m_k == m_kexp);
        chk("sym_valid", 32'(sym_valid), 32'(exp_v));
        if (exp_v) begin
            w = win(m_nxt);
            t = tok_idx(w);
            if (t >= 0) begin
                m_de = 0;
                m_ctrl = 2'(t);
            end else begin
                m_de = 1;
                m_data = ref_data(w);
            end
            chk("sym", 32'(sym), 32'(w));
            chk("de", 32'(de), 32'(m_de));
            chk("data", 32'(data), 32'(m_data));
            chk("ctrl", 32'(ctrl), 32'(m_ctrl));
            step = 10;
            if (!m_lock) begin
                if (t >= 0) begin
                    m_miss = 0;
                    m_hit++;
                    if (m_hit == 8) begin
                        m_lock = 1; m_hit = 0; m_loss = 0;
                    end
                end else begin
                    m_hit = 0;
                    m_miss++;
                    if (m_miss == 16) begin
                        m_pend = 1; m_miss = 0; step = 11;
                    end
                end
            end else begin
                if (t >= 0) m_loss = 0;
                else begin
                    m_loss++;
                    if (m_loss == 4096) begin
                        m_lock = 0; m_loss = 0; m_hit = 0; m_miss = 0;
                    end
                end
            end
            m_nxt += step;
            m_kexp = (m_nxt + 12) / 2;
        end
        chk("locked", 32'(locked), 32'(m_lock));
        chk("slip_count", 32'(slip_count), 32'(m_slip));
        m_k++;
    endtask

    // serial driver: two bits per clock from the pending queue
    initial begin
        bit b;
        forever begin
            @(negedge clk_shift);
            if (!rst_n) begin
                in_bits = 2'b00;
                pend.delete();
                hist.delete();
            end else begin
                for (int j = 0; j < 2; j++) begin
                    b = (pend.size() > 0) ? pend.pop_front() : 1'b0;
                    in_bits[j] = b;
                    hist.push_back(b);
                end
            end
        end
    end

    // monitor: steps the model once per clock, 1 time unit after the edge
    initial begin
        bit mon_rst;
        model_reset();
        forever begin
            @(posedge clk_shift);
            mon_rst = rst_n;
            #1;
            if (!mon_rst) model_reset();
            else model_edge();
        end
    end

    task automatic push_bits(input logic [9:0] w, input int n);
        for (int j = 0; j < n; j++) pend.push_back(w[j]);
    endtask

    task automatic send_sym(input logic [9:0] w);
        while (pend.size() > 20) @(negedge clk_shift);
        push_bits(w, 10);
    endtask

    task automatic do_reset();
        @(posedge clk_shift);
        #2 rst_n = 1'b0;
        @(posedge clk_shift);
        #2 rst_n = 1'b1;
    endtask

    task automatic chk_reset();
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym", 32'(sym), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_slip", 32'(slip_count), 32'd0);
    endtask

    initial begin
        int guard, n, kind;
        repeat (2) @(posedge clk_shift);
        #2 rst_n = 1'b1;
        chk_reset();

        // aligned C00 tokens
        push_bits(10'd0, 6);
        for (int i = 0; i < 20; i++) send_sym(10'b1101010100);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_slip", 32'(slip_count), 32'd0);
        chk("t1_ctrl", 32'(ctrl), 32'd0);
        chk("t1_de", 32'(de), 32'd0);

        // C01 tokens, three bits early against the receiver
        do_reset();
        push_bits(10'd0, 3);
        for (int i = 0; i < 150; i++) send_sym(10'b0010101011);
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_slip", 32'(slip_count), 32'd7);
        chk("t2_ctrl", 32'(ctrl), 32'd1);
        chk("t2_de", 32'(de), 32'd0);

        // data decode while locked
        send_sym(10'h100);
        send_sym(10'h200);
        for (int i = 0; i < 8; i++) send_sym(10'b1010101011);
        chk("t3_data", 32'(data), 32'hFF);
        chk("t3_ctrl", 32'(ctrl), 32'd3);
        chk("t3_de", 32'(de), 32'd0);
        chk("t3_locked", 32'(locked), 32'd1);

        // loss of lock, then search slipping again
        for (int i = 0; i < 4096 + 44; i++) send_sym(10'h100);
        chk("t4_locked", 32'(locked), 32'd0);
        chk("t4_slip", 32'(slip_count), 32'd9);

        // reset in the middle of search
        do_reset();
        guard = 0;
        while (m_slip != 5 && guard < 400) begin
            send_sym(10'h100);
            guard++;
        end
        chk("t5_pre_rst_slip", 32'(slip_count), 32'd5);
        do_reset();
        chk_reset();

        // data-only stream walks through all ten alignments
        for (int i = 0; i < 175; i++) send_sym(10'h100);
        chk("t6_slip_wrap", 32'(slip_count), 32'd0);
        chk("t6_locked", 32'(locked), 32'd0);

        // randomized bursts of tokens and data
        do_reset();
        push_bits(10'd0, $urandom_range(0, 9));
        for (int b = 0; b < 40; b++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                n = $urandom_range(1, 12);
                kind = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) send_sym(tok_word(kind));
            end else begin
                n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) send_sym(10'($urandom));
            end
        end

        while (pend.size() > 0) @(negedge clk_shift);
        repeat (10) @(negedge clk_shift);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_lane_receiver.md
Name: tmds_lane_receiver

Overview:
Receive side of one DVI/TMDS lane. Takes the 2-bit-per-clock serial stream that our transmitter shift registers emit in DDR mode, finds 10-bit symbol alignment from control tokens, and decodes each symbol to 8-bit pixel data or 2-bit control. One instance per lane (blue, green, red) sits behind the input DDR register in the capture/loopback test path.

Parameters:
C_lock_count, 8, consecutive aligned control tokens required to enter LOCKED
C_slip_after, 16, consecutive non-token symbols in SEARCH before a 1-bit slip
C_loss_window, 4096, symbols without any control token in LOCKED before returning to SEARCH

Ports:
clk_shift  input  1  shift clock; one 2-bit pair per edge; sole clock
rst_n  input  1  synchronous active-low reset
in_bits  input  2  serial pair; in_bits[0] is the earlier bit; symbols are sent LSB first
sym_valid  output  1  one-cycle pulse, one per symbol (every 5 clocks)
sym  output  10  raw aligned symbol
data  output  8  decoded pixel byte; valid when de=1
ctrl  output  2  decoded control bits {c1,c0}; valid when de=0
de  output  1  1 = data symbol, 0 = control token
locked  output  1  alignment state is LOCKED
slip_count  output  4  current bit alignment 0..9 (diagnostic)

Behaviour:
- One clock (clk_shift); reset is synchronous and active-low (rst_n).
- Reset: sym_valid=0, sym=0, data=0, ctrl=0, de=0, locked=0, slip_count=0; phase=0, offset=0, state SEARCH, all counters 0. Reset overrides everything, including in-progress slip or lock.
- Capture: 12-bit shift register sr <= {in_bits[1], in_bits[0], sr[11:2]} every cycle. Candidate word = sr[offset+9 : offset], offset in {0,1}; sr[offset] is bit 0.
- Phase counter 0..4 increments every cycle, wraps 4->0. Symbol strobe when phase==4.
- On strobe, register sym, decode, and pulse sym_valid on the next cycle. Latency: sym_valid is high 2 clocks after the clock that presented the last bit of the symbol.
- Control tokens: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11; these set de=0 and ctrl; data holds its previous value.
- Data decode (any other word): de=1; x = d[9] ? ~d[7:0] : d[7:0]; data[0]=x[0]; for i=1..7, data[i] = d[8] ? x[i]^x[i-1] : ~(x[i]^x[i-1]); ctrl holds.
- Slip by one bit: offset 0->1; offset 1->0 with the phase increment suppressed for one cycle. slip_count increments mod 10. Ten slips return to the original alignment. No strobe is evaluated in the cycle in which a slip occurs; the hit/miss counters clear.
- FSM SEARCH: on each strobe, a token increments hit and clears miss; a non-token clears hit and increments miss. hit==C_lock_count -> LOCKED. miss==C_slip_after -> slip.
- FSM LOCKED: locked=1; no slips. Any token clears the loss counter; otherwise it increments per symbol. Reaching C_loss_window -> SEARCH, locked=0 on the next cycle, counters cleared.
- sym_valid/decode outputs run in both states. Downstream logic uses them only when locked=1.
- Counters saturate at their thresholds and never wrap.

Decomposition:
- Package tmds_pkg: the four control-token constants, token->ctrl mapping, and the SEARCH/LOCKED state enum. The transmitter side reuses the same token constants.
- Sub-module tmds_decode_10to8: purely combinational; outputs data, ctrl, de and is_token for a 10-bit word. The top holds the shift register, phase/offset, FSM and output registers.

Test Plan:
- Aligned tokens: 20 symbols of 1101010100 at alignment 0 -> locked=1 after the 8th token. ctrl=00, de=0, sym_valid every 5 clocks, slip_count=0.
- Misaligned by 3 bits: repeated 0010101011 with a 3-bit leading pad -> slips occur every 16 symbols until slip_count=7 (10-3). Then lock after 8 tokens, ctrl=01.
- Data decode while locked: 0x100 -> data=0x00, de=1; 0x200 -> data=0xFF, de=1; next token 1010101011 -> de=0, ctrl=11, data stays 0xFF.
- Loss of lock: after lock, 4096 consecutive 0x100 symbols -> locked drops on symbol 4096. Then SEARCH slip behaviour resumes.
- Reset mid-search: assert rst_n=0 for one cycle with slip_count=5 -> all outputs 0 next cycle, slip_count=0, phase restarts at 0.
- Slip wrap: feed only data symbols for 160 symbols -> exactly 10 slips, slip_count returns to 0, locked stays 0.
